conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 82 ++++++++
 tb/tb_conv_window_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: column-major tile scanner producing 3x3 pixel windows with tile bookkeeping
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int TILE_H = 10,
    parameter int TILE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  in_tile_start,
    input  logic [DATA_W-1:0]     in_pix,
    output logic                  out_valid,
    output logic [9*DATA_W-1:0]   out_win,
    output logic [6:0]            out_row,
    output logic [6:0]            out_col,
    output logic [1:0]            out_quad,
    output logic                  tile_done,
    output logic                  err_abort
);
    localparam int RW = TILE_H > 1 ? $clog2(TILE_H) : 1;
    localparam int CW = TILE_W > 1 ? $clog2(TILE_W) : 1;
    logic [RW-1:0] r, pr, nr;
    logic [CW-1:0] c, pc, nc;
    logic [DATA_W-1:0] col_a [TILE_H];
    logic [DATA_W-1:0] col_b [TILE_H];
    logic [2:0][2:0][DATA_W-1:0] sh, nsh;
    logic acc, at_zero, at_last, restart, abort, row_end, win_ok, done;
    always_comb begin
        acc     = en & in_valid;
        at_zero = r == '0 && c == '0;
        at_last = r == RW'(TILE_H-1) && c == CW'(TILE_W-1);
        // a start flag on the final pixel is ignored so the completing tile is not lost
        restart = in_tile_start && !at_last;
        abort   = acc && restart && !at_zero;
        pr      = restart ? '0 : r;
        pc      = restart ? '0 : c;
        row_end = pr == RW'(TILE_H-1);
        nr      = row_end ? '0 : pr + RW'(1);
        nc      = row_end ? (pc == CW'(TILE_W-1) ? '0 : pc + CW'(1)) : pc;
        win_ok  = pr >= RW'(2) && pc >= CW'(2);
        done    = acc && row_end && pc == CW'(TILE_W-1);
        nsh[2]  = {in_pix, col_a[pr], col_b[pr]};
        nsh[1]  = pr == '0 ? '0 : sh[2];
        nsh[0]  = pr == '0 ? '0 : sh[1];
    end
    always_ff @(posedge clk) begin
        if (acc) begin
            col_a[pr] <= in_pix;
            col_b[pr] <= col_a[pr];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r         <= '0;
            c         <= '0;
            sh        <= '0;
            out_quad  <= '0;
            out_valid <= 1'b0;
            tile_done <= 1'b0;
            err_abort <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_win   <= '0;
        end else begin
            out_valid <= acc && win_ok;
            tile_done <= done;
            err_abort <= abort;
            if (acc) begin
                r  <= nr;
                c  <= nc;
                sh <= nsh;
            end
            if (acc && win_ok) begin
                out_win <= nsh;
                out_row <= 7'(pr);
                out_col <= 7'(pc);
            end
            if (done) out_quad <= out_quad + 2'd1;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench for conv_window_gen using pixel value c*16+r+offset per tile
module tb_conv_window_gen;
    logic clk = 0, rst = 0, en = 0, in_valid = 0, in_tile_start = 0;
    logic [7:0] in_pix = 0;
    logic out_valid, tile_done, err_abort;
    logic [71:0] out_win;
    logic [6:0] out_row, out_col;
    logic [1:0] out_quad;
    int nchk = 0, nerr = 0, nwin = 0;
    logic [71:0] last_win = 0, first_win = 0;
    logic [6:0] last_row = 0, last_col = 0, first_row = 0, first_col = 0;
    logic [1:0] q = 0;

    conv_window_gen #(.DATA_W(8), .TILE_H(10), .TILE_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_tile_start(in_tile_start),
        .in_pix(in_pix), .out_valid(out_valid), .out_win(out_win), .out_row(out_row),
        .out_col(out_col), .out_quad(out_quad), .tile_done(tile_done), .err_abort(err_abort)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pv(int r, int c, int off);
        return 8'(c * 16 + r + off);
    endfunction

    function automatic logic [71:0] ew(int r, int c, int off);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = pv(r - 2 + i, c - 2 + j, off);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic v, input logic ts, input logic [7:0] p);
        en = e; in_valid = v; in_tile_start = ts; in_pix = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_win"}, out_win, last_win);
        chk({tag, "_row"}, out_row, last_row);
        chk({tag, "_col"}, out_col, last_col);
        chk({tag, "_done"}, tile_done, 0);
        chk({tag, "_abort"}, err_abort, 0);
    endtask

    task automatic pix_at(input int idx, input int off, input logic ts, input logic exp_ab);
        int r, c;
        logic v;
        r = idx % 10;
        c = idx / 10;
        cyc(1, 1, ts, pv(r, c, off));
        v = r >= 2 && c >= 2;
        chk("valid", out_valid, v);
        chk("done", tile_done, r == 9 && c == 7);
        chk("abort", err_abort, exp_ab);
        if (v) begin
            chk("win", out_win, ew(r, c, off));
            chk("row", out_row, 7'(r));
            chk("col", out_col, 7'(c));
            if (nwin == 0) begin
                first_win = out_win; first_row = out_row; first_col = out_col;
            end
            nwin++;
            last_win = ew(r, c, off); last_row = 7'(r); last_col = 7'(c);
        end
    endtask

    task automatic feed(input int off, input int gap, input int first, input int last,
                        input logic use_ts, input logic ts_last, input logic ab0);
        nwin = 0;
        for (int i = first; i < last; i++) begin
            pix_at(i, off, (i == 0 && use_ts) || (i == 79 && ts_last), ab0 && i == 0);
            if (gap == 1) begin
                cyc(1, 0, 1, 8'hFF);
                idle_chk("gap");
            end
            if (gap == 2 && i % 7 == 3)
                repeat (3) begin
                    cyc(0, 1, 1, 8'hEE);
                    idle_chk("hold");
                end
        end
        if (first == 0 && last == 80) begin
            q = q + 2'd1;
            chk("nwin", nwin, 48);
            chk("quad", out_quad, q);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_win", out_win, 0);
        chk("rst_quad", out_quad, 0);
        chk("rst_done", tile_done, 0);
        rst = 1;
        // first tile, plain streaming
        feed(0, 0, 0, 80, 1, 0, 0);
        chk("first_w00", first_win[7:0], 8'h00);
        chk("first_w22", first_win[71:64], 8'h22);
        chk("first_row", first_row, 2);
        chk("first_col", first_col, 2);
        chk("last_w00", out_win[7:0], 8'h57);
        chk("last_w22", out_win[71:64], 8'h79);
        // restart mid-tile at (5,3)
        feed(8'h80, 0, 0, 35, 1, 0, 0);
        feed(8'h40, 0, 0, 80, 1, 0, 1);
        chk("ab_w00", first_win[7:0], 8'h40);
        chk("ab_w22", first_win[71:64], 8'h62);
        chk("ab_row", first_row, 2);
        chk("ab_col", first_col, 2);
        // throttled input
        feed(8'h10, 1, 0, 80, 1, 0, 0);
        feed(8'h20, 2, 0, 80, 1, 0, 0);
        // four back-to-back tiles, only the first flagged
        chk("quad0", out_quad, 0);
        feed(8'h00, 0, 0, 80, 1, 0, 0);
        feed(8'h80, 0, 0, 80, 0, 1, 0);
        feed(8'h00, 0, 0, 80, 0, 0, 0);
        feed(8'h80, 0, 0, 80, 0, 0, 0);
        // reset mid-tile at (7,4)
        feed(8'h33, 0, 0, 47, 1, 0, 0);
        rst = 0;
        cyc(1, 1, 0, 8'hAA);
        chk("mr_valid", out_valid, 0);
        chk("mr_win", out_win, 0);
        chk("mr_row", out_row, 0);
        chk("mr_col", out_col, 0);
        chk("mr_quad", out_quad, 0);
        chk("mr_done", tile_done, 0);
        chk("mr_abort", err_abort, 0);
        rst = 1;
        q = 0; last_win = 0; last_row = 0; last_col = 0;
        feed(8'h20, 0, 0, 80, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
